// File: rtl/csi_rx_pkg.sv
// Shared RAW10 definitions for the CSI-2 receive pixel path.
package csi_rx_pkg;

  localparam int unsigned RAW10_GROUP_BYTES   = 5;
  localparam int unsigned RAW10_PIX_W         = 10;
  localparam int unsigned RAW10_PIX_PER_GROUP = 4;
  localparam int unsigned RAW10_GROUP_W       = RAW10_PIX_PER_GROUP * RAW10_PIX_W;

  // Element n is pixel n; pixel 0 occupies the low bits.
  typedef logic [RAW10_PIX_PER_GROUP-1:0][RAW10_PIX_W-1:0] raw10_group_t;

  // Bytes 0..3 carry the pixel MSBs; byte 4 packs the four 2-bit LSB pairs.
  function automatic raw10_group_t raw10_decode(input logic [8*RAW10_GROUP_BYTES-1:0] grp_bytes);
    raw10_group_t grp;
    for (int n = 0; n < int'(RAW10_PIX_PER_GROUP); n++) begin
      grp[n] = {grp_bytes[8*n +: 8], grp_bytes[8*RAW10_PIX_PER_GROUP + 2*n +: 2]};
    end
    return grp;
  endfunction

endpackage

// File: rtl/csi_rx_raw10_linecheck.sv
// Per-line group counter, end-of-line length/residual compare and sticky error flag.
module csi_rx_raw10_linecheck
  import csi_rx_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = 1280,
  parameter int unsigned CNT_W       = 12
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic frame_rise_i,
  input  logic frame_fall_i,
  input  logic group_i,
  input  logic residual_i,
  input  logic vsync_i,
  output logic line_err_o,
  output logic line_err_sticky_o
);

  localparam int unsigned CMP_W = CNT_W + 2;

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    count_d  = count_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    if (frame_rise_i) begin
      count_d = '0;
    end
    // Saturate so an overlong line cannot wrap back to a matching count.
    if (group_i && (count_d != {CNT_W{1'b1}})) begin
      count_d = count_d + CNT_W'(1);
    end

    if (frame_fall_i) begin
      err_d = ({count_q, 2'b00} != CMP_W'(LINE_PIXELS)) || residual_i;
    end

    if (vsync_i) begin
      sticky_d = 1'b0;
    end
    if (err_d) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign line_err_o        = err_q;
  assign line_err_sticky_o = sticky_q;

endmodule

// File: rtl/csi_rx_raw10_unpack.sv
// Repacks the 32-bit CSI-2 payload word stream into registered 4-pixel RAW10 groups.
// Optional per-line length checking is compiled in with CSI_RX_RAW10_LINE_CHECK_EN.
module csi_rx_raw10_unpack
  import csi_rx_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = 1280,
  parameter int unsigned CNT_W       = 12
) (
  input  logic        clock,
  input  logic        areset_n,
  input  logic [31:0] payload_data,
  input  logic        payload_enable,
  input  logic        payload_frame,
  input  logic        vsync,
  output logic [39:0] pixel_data,
  output logic        pixel_valid,
  output logic        pixel_line_start,
  output logic        pixel_vsync,
  output logic        line_err,
  output logic        line_err_sticky
);

  localparam int unsigned BUF_W   = 64;
  localparam int unsigned OCC_W   = 4;
  localparam int unsigned GRP_W   = 8 * RAW10_GROUP_BYTES;

  if (((LINE_PIXELS % 4) != 0) || ((LINE_PIXELS / 4) >= (1 << CNT_W))) begin : g_bad_params
    $error("csi_rx_raw10_unpack: LINE_PIXELS must be a multiple of 4 and LINE_PIXELS/4 must fit in CNT_W");
  end

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             frame_q;
  logic             first_q, first_d;
  raw10_group_t     pix_q, pix_d;
  logic             valid_q, start_q, start_d, vsync_q;

  logic             accept, frame_rise, frame_fall, emit, first_now;
  logic [BUF_W-1:0] base_buf, cat_buf;
  logic [OCC_W-1:0] base_occ, cat_occ;

  always_comb begin
    accept     = payload_enable & payload_frame;
    frame_rise = payload_frame & ~frame_q;
    frame_fall = ~payload_frame & frame_q;
    first_now  = first_q | frame_rise;

    // A new line always appends to an empty buffer.
    base_buf = frame_rise ? '0 : buf_q;
    base_occ = frame_rise ? '0 : occ_q;

    cat_buf = base_buf;
    cat_occ = base_occ;
    if (accept) begin
      cat_buf = base_buf | (BUF_W'(payload_data) << {base_occ, 3'b000});
      cat_occ = base_occ + OCC_W'(4);
    end
    emit = (cat_occ >= OCC_W'(RAW10_GROUP_BYTES));

    buf_d   = cat_buf;
    occ_d   = cat_occ;
    pix_d   = pix_q;
    start_d = 1'b0;
    first_d = first_now;

    if (emit) begin
      buf_d   = cat_buf >> GRP_W;
      occ_d   = cat_occ - OCC_W'(RAW10_GROUP_BYTES);
      pix_d   = raw10_decode(cat_buf[GRP_W-1:0]);
      start_d = first_now;
      first_d = 1'b0;
    end

    // Line end drops any residual bytes.
    if (frame_fall) begin
      buf_d   = '0;
      occ_d   = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      buf_q   <= '0;
      occ_q   <= '0;
      frame_q <= 1'b0;
      first_q <= 1'b0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      occ_q   <= occ_d;
      frame_q <= payload_frame;
      first_q <= first_d;
      pix_q   <= pix_d;
      valid_q <= emit;
      start_q <= start_d;
      vsync_q <= vsync;
    end
  end

  assign pixel_data       = pix_q;
  assign pixel_valid      = valid_q;
  assign pixel_line_start = start_q;
  assign pixel_vsync      = vsync_q;

`ifdef CSI_RX_RAW10_LINE_CHECK_EN
  csi_rx_raw10_linecheck #(
    .LINE_PIXELS (LINE_PIXELS),
    .CNT_W       (CNT_W)
  ) u_linecheck (
    .clk_i             (clock),
    .rst_n_i           (areset_n),
    .frame_rise_i      (frame_rise),
    .frame_fall_i      (frame_fall),
    .group_i           (emit),
    .residual_i        (occ_q != '0),
    .vsync_i           (vsync),
    .line_err_o        (line_err),
    .line_err_sticky_o (line_err_sticky)
  );
`else
  assign line_err        = 1'b0;
  assign line_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_csi_rx_raw10_unpack.sv
// Directed self-checking bench for csi_rx_raw10_unpack (default LINE_PIXELS=1280).
module tb_csi_rx_raw10_unpack;

  logic        clock = 1'b0;
  logic        areset_n;
  logic [31:0] payload_data;
  logic        payload_enable;
  logic        payload_frame;
  logic        vsync;
  logic [39:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_line_start;
  logic        pixel_vsync;
  logic        line_err;
  logic        line_err_sticky;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

`ifdef CSI_RX_RAW10_LINE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  csi_rx_raw10_unpack #(
    .LINE_PIXELS (1280),
    .CNT_W       (12)
  ) dut (
    .clock            (clock),
    .areset_n         (areset_n),
    .payload_data     (payload_data),
    .payload_enable   (payload_enable),
    .payload_frame    (payload_frame),
    .vsync            (vsync),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_line_start (pixel_line_start),
    .pixel_vsync      (pixel_vsync),
    .line_err         (line_err),
    .line_err_sticky  (line_err_sticky)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic fr, input logic [31:0] d, input logic vs);
    payload_enable = en;
    payload_frame  = fr;
    payload_data   = d;
    vsync          = vs;
  endtask

  function automatic logic [7:0] sbyte(input int idx);
    return 8'(idx & 255);
  endfunction

  // Word whose byte 0 is stream byte idx.
  function automatic logic [31:0] word_seq(input int idx);
    return {sbyte(idx + 3), sbyte(idx + 2), sbyte(idx + 1), sbyte(idx)};
  endfunction

  // Expected 4-pixel group for stream bytes idx..idx+4, built arithmetically.
  function automatic logic [39:0] grp_seq(input int idx);
    logic [39:0] g;
    int          b4;
    int          p;
    g  = '0;
    b4 = idx + 4;
    for (int n = 0; n < 4; n++) begin
      p = int'(sbyte(idx + n)) * 4 + ((int'(sbyte(b4)) >> (2 * n)) % 4);
      g = g | (40'(p) << (10 * n));
    end
    return g;
  endfunction

  initial begin
    int          grp;
    int          groups;
    logic [39:0] last;

    areset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    check("rst_valid", 64'(pixel_valid), 64'(0));
    check("rst_data", 64'(pixel_data), 64'(0));
    check("rst_start", 64'(pixel_line_start), 64'(0));
    check("rst_vsync", 64'(pixel_vsync), 64'(0));
    check("rst_err", 64'(line_err), 64'(0));
    check("rst_sticky", 64'(line_err_sticky), 64'(0));
    areset_n = 1'b1;
    tick();

    // vsync passes through with one cycle of delay.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("vsync_dly_hi", 64'(pixel_vsync), 64'(1));
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("vsync_dly_lo", 64'(pixel_vsync), 64'(0));

    // Five words of bytes 0x01..0x14 give four groups.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, word_seq(1 + 4 * i), 1'b0);
      tick();
      check("seq_valid", 64'(pixel_valid), 64'(i != 0));
      if (i != 0) begin
        check("seq_data", 64'(pixel_data), 64'(grp_seq(1 + 5 * (i - 1))));
        check("seq_start", 64'(pixel_line_start), 64'(i == 1));
      end
      if (i == 1) begin
        check("seq_g0_const", 64'(pixel_data), 64'({10'h010, 10'h00C, 10'h009, 10'h005}));
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("seq_end_valid", 64'(pixel_valid), 64'(0));
    check("seq_hold", 64'(pixel_data), 64'(grp_seq(16)));
    check("short_line_err", 64'(line_err), 64'(CHK));
    tick();
    check("short_err_pulse", 64'(line_err), 64'(0));
    check("short_sticky", 64'(line_err_sticky), 64'(CHK));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("vsync_clears_sticky", 64'(line_err_sticky), 64'(0));
    tick();

    // Full 1600-byte line: every group checked, no error at line end.
    groups = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, 1'b1, word_seq(4 * i), 1'b0);
      tick();
      check("full_valid", 64'(pixel_valid), 64'((i % 5) != 0));
      if (pixel_valid) begin
        grp = (i / 5) * 4 + (i % 5) - 1;
        check("full_data", 64'(pixel_data), 64'(grp_seq(5 * grp)));
        check("full_start", 64'(pixel_line_start), 64'(grp == 0));
        groups++;
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("full_groups", 64'(groups), 64'(320));
    check("full_err", 64'(line_err), 64'(0));
    tick();
    check("full_sticky", 64'(line_err_sticky), 64'(0));

    // 401 words: 320 groups plus residual bytes; vsync coincides with line end.
    groups = 0;
    for (int i = 0; i < 401; i++) begin
      drive(1'b1, 1'b1, word_seq(4 * i), 1'b0);
      tick();
      if (pixel_valid) groups++;
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("resid_groups", 64'(groups), 64'(320));
    check("resid_err", 64'(line_err), 64'(CHK));
    check("resid_sticky_set_wins", 64'(line_err_sticky), 64'(CHK));
    tick();
    check("resid_err_pulse", 64'(line_err), 64'(0));
    check("resid_sticky_hold", 64'(line_err_sticky), 64'(CHK));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("resid_sticky_clr", 64'(line_err_sticky), 64'(0));
    tick();

    // Idle cycle between words: same groups, one cycle after the completing word.
    last = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, word_seq(1 + 4 * i), 1'b0);
      tick();
      check("gap_valid", 64'(pixel_valid), 64'(i != 0));
      if (i != 0) begin
        last = grp_seq(1 + 5 * (i - 1));
        check("gap_data", 64'(pixel_data), 64'(last));
        check("gap_start", 64'(pixel_line_start), 64'(i == 1));
      end
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      tick();
      check("gap_idle_valid", 64'(pixel_valid), 64'(0));
      if (i != 0) check("gap_idle_hold", 64'(pixel_data), 64'(last));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset after three words discards the partial line.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, word_seq(1 + 4 * i), 1'b0);
      tick();
    end
    check("pre_rst_valid", 64'(pixel_valid), 64'(1));
    #2;
    areset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("midrst_valid", 64'(pixel_valid), 64'(0));
    check("midrst_data", 64'(pixel_data), 64'(0));
    check("midrst_start", 64'(pixel_line_start), 64'(0));
    tick();
    areset_n = 1'b1;
    tick();
    drive(1'b1, 1'b1, word_seq(32'hA0), 1'b0);
    tick();
    check("post_rst_w0_valid", 64'(pixel_valid), 64'(0));
    drive(1'b1, 1'b1, word_seq(32'hA4), 1'b0);
    tick();
    check("post_rst_valid", 64'(pixel_valid), 64'(1));
    check("post_rst_data", 64'(pixel_data), 64'(grp_seq(32'hA0)));
    check("post_rst_start", 64'(pixel_line_start), 64'(1));
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Enable without frame is ignored entirely.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      tick();
      check("noframe_valid", 64'(pixel_valid), 64'(0));
    end
    drive(1'b1, 1'b1, word_seq(32'h40), 1'b0);
    tick();
    check("noframe_w0_valid", 64'(pixel_valid), 64'(0));
    drive(1'b1, 1'b1, word_seq(32'h44), 1'b0);
    tick();
    check("noframe_next_valid", 64'(pixel_valid), 64'(1));
    check("noframe_next_data", 64'(pixel_data), 64'(grp_seq(32'h40)));
    check("noframe_next_start", 64'(pixel_line_start), 64'(1));
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
